// File: rtl/issue_pair_sequencer_if.sv
// Decode-pair / execute-lane bundle for issue_pair_sequencer.
// ISSUE_PERF_CNT_EN adds the two performance counter outputs.
interface issue_pair_sequencer_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            PairValidD;
  logic            PairReadyD;
  logic            ValidD1;
  logic            ValidD2;
  logic [ILEN-1:0] InstrD1;
  logic [ILEN-1:0] InstrD2;
  logic [XLEN-1:0] PCD1;
  logic [XLEN-1:0] PCD2;
  logic            DepD;
  logic            StallE;
  logic            FlushD;
  logic            ValidE1;
  logic            ValidE2;
  logic [ILEN-1:0] InstrE1;
  logic [ILEN-1:0] InstrE2;
  logic [XLEN-1:0] PCE1;
  logic [XLEN-1:0] PCE2;
  logic            SplitActive;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0]     DualIssueCnt;
  logic [31:0]     SplitCnt;
`endif

  modport master (
    output PairValidD, ValidD1, ValidD2, InstrD1, InstrD2, PCD1, PCD2,
           DepD, StallE, FlushD,
    input  PairReadyD, ValidE1, ValidE2, InstrE1, InstrE2, PCE1, PCE2,
           SplitActive
`ifdef ISSUE_PERF_CNT_EN
    , input DualIssueCnt, SplitCnt
`endif
  );

  modport slave (
    input  PairValidD, ValidD1, ValidD2, InstrD1, InstrD2, PCD1, PCD2,
           DepD, StallE, FlushD,
    output PairReadyD, ValidE1, ValidE2, InstrE1, InstrE2, PCE1, PCE2,
           SplitActive
`ifdef ISSUE_PERF_CNT_EN
    , output DualIssueCnt, SplitCnt
`endif
  );
endinterface

// File: rtl/issue_pair_sequencer.sv
// Turns a decoded instruction pair plus its dependency flag into execute-lane issue:
// independent pairs issue together, dependent pairs split over two cycles. ISSUE_PERF_CNT_EN adds counters.
module issue_pair_sequencer #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input logic                    clk,
  input logic                    rst,
  issue_pair_sequencer_if.slave  bus
);

  typedef enum logic {DUAL, SPLIT} state_e;

  state_e          state_q, state_d;
  logic            valid_e1_q, valid_e1_d;
  logic            valid_e2_q, valid_e2_d;
  logic [ILEN-1:0] instr_e1_q, instr_e1_d;
  logic [ILEN-1:0] instr_e2_q, instr_e2_d;
  logic [XLEN-1:0] pc_e1_q, pc_e1_d;
  logic [XLEN-1:0] pc_e2_q, pc_e2_d;
  logic            hold_valid_q, hold_valid_d;
  logic [ILEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic            ready;
  logic            accept;

  assign ready  = (state_q == DUAL) && !bus.StallE && !bus.FlushD;
  assign accept = bus.PairValidD && ready;

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first so no path infers a latch.
    state_d      = state_q;
    valid_e1_d   = valid_e1_q;
    valid_e2_d   = valid_e2_q;
    instr_e1_d   = instr_e1_q;
    instr_e2_d   = instr_e2_q;
    pc_e1_d      = pc_e1_q;
    pc_e2_d      = pc_e2_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;

    if (bus.FlushD) begin
      valid_e1_d   = 1'b0;
      valid_e2_d   = 1'b0;
      state_d      = DUAL;
      hold_valid_d = 1'b0;
    end else if (!bus.StallE) begin
      case (state_q)
        DUAL: begin
          valid_e1_d = 1'b0;
          valid_e2_d = 1'b0;
          if (accept) begin
            valid_e1_d = bus.ValidD1;
            instr_e1_d = bus.InstrD1;
            pc_e1_d    = bus.PCD1;
            // Dependency only matters when both slots are real instructions.
            if (bus.ValidD1 && bus.ValidD2 && bus.DepD) begin
              hold_valid_d = 1'b1;
              hold_instr_d = bus.InstrD2;
              hold_pc_d    = bus.PCD2;
              state_d      = SPLIT;
            end else begin
              valid_e2_d = bus.ValidD2;
              instr_e2_d = bus.InstrD2;
              pc_e2_d    = bus.PCD2;
            end
          end
        end
        SPLIT: begin
          valid_e1_d   = 1'b0;
          valid_e2_d   = hold_valid_q;
          instr_e2_d   = hold_instr_q;
          pc_e2_d      = hold_pc_q;
          hold_valid_d = 1'b0;
          state_d      = DUAL;
        end
        default: state_d = DUAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= DUAL;
      valid_e1_q   <= 1'b0;
      valid_e2_q   <= 1'b0;
      instr_e1_q   <= '0;
      instr_e2_q   <= '0;
      pc_e1_q      <= '0;
      pc_e2_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      valid_e1_q   <= valid_e1_d;
      valid_e2_q   <= valid_e2_d;
      instr_e1_q   <= instr_e1_d;
      instr_e2_q   <= instr_e2_d;
      pc_e1_q      <= pc_e1_d;
      pc_e2_q      <= pc_e2_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  assign bus.PairReadyD  = ready;
  assign bus.ValidE1     = valid_e1_q;
  assign bus.ValidE2     = valid_e2_q;
  assign bus.InstrE1     = instr_e1_q;
  assign bus.InstrE2     = instr_e2_q;
  assign bus.PCE1        = pc_e1_q;
  assign bus.PCE2        = pc_e2_q;
  assign bus.SplitActive = (state_q == SPLIT);

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] dual_cnt_q;
  logic [31:0] split_cnt_q;

  // Counters track what lands in the E registers, so they freeze exactly when those do.
  always_ff @(posedge clk) begin
    if (rst) begin
      dual_cnt_q  <= '0;
      split_cnt_q <= '0;
    end else if (!bus.StallE) begin
      if (valid_e1_d && valid_e2_d)
        dual_cnt_q <= dual_cnt_q + 32'd1;
      if (state_q == DUAL && state_d == SPLIT)
        split_cnt_q <= split_cnt_q + 32'd1;
    end
  end

  assign bus.DualIssueCnt = dual_cnt_q;
  assign bus.SplitCnt     = split_cnt_q;
`endif

endmodule
